// File: rtl/mealy_run_zero_detector.sv
// mealy_run_zero_detector: flags a 0 that ends a run of 1s whose length lies in [MIN_ONES, MAX_ONES],
// with a registered copy of the flag and a saturating detection counter with a sticky overflow bit.
module mealy_run_zero_detector #(
    parameter int MIN_ONES = 1,
    parameter int MAX_ONES = 0,
    parameter int RUN_W    = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             clr_cnt,
    output logic             y,
    output logic             y_q,
    output logic [1:0]       state,
    output logic [RUN_W-1:0] run_len,
    output logic [CNT_W-1:0] det_cnt,
    output logic             det_ovf
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, ARMED = 2'b10, OVER = 2'b11} state_t;
    localparam logic [RUN_W-1:0] MIN_L = RUN_W'(MIN_ONES);
    localparam logic [RUN_W-1:0] MAX_L = RUN_W'(MAX_ONES);
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, in_win, cnt_full;
    state_t           st;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= '0;
            y_q   <= 1'b0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            run_q <= run_d;
            y_q   <= y;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
    // State is a pure decode of the run length; no separate state register exists.
    always_comb begin
        in_win   = (run_q >= MIN_L) && (MAX_ONES == 0 || run_q <= MAX_L);
        y        = en & ~x & in_win;
        run_d    = !en ? run_q : !x ? '0 : (&run_q) ? run_q : run_q + 1'b1;
        st       = run_q == '0 ? IDLE : run_q < MIN_L ? RUN : in_win ? ARMED : OVER;
        cnt_full = &cnt_q;
        cnt_d    = clr_cnt ? CNT_W'(y) : (y && cnt_full) ? cnt_q : cnt_q + CNT_W'(y);
        ovf_d    = !clr_cnt && (ovf_q || (y && cnt_full));
    end
    assign state   = st;
    assign run_len = run_q;
    assign det_cnt = cnt_q;
    assign det_ovf = ovf_q;
endmodule

// File: tb/tb_mealy_run_zero_detector.sv
// tb_mealy_run_zero_detector: drives a legacy-configured and a windowed detector from one stream
// and compares both against an unbounded run/hit-count model.
module tb_mealy_run_zero_detector;
    logic       clk = 1'b0, rst = 1'b0, en = 1'b0, x = 1'b0, clr_cnt = 1'b0;
    logic       y_l, yq_l, ovf_l, y_w, yq_w, ovf_w;
    logic [1:0] st_l, st_w;
    logic [2:0] run_l;
    logic [3:0] run_w;
    logic [1:0] cnt_l;
    logic [7:0] cnt_w;
    int total = 0, bad = 0;
    int run = 0, hl = 0, hw = 0;
    bit ol = 0, ow = 0, yql = 0, yqw = 0;

    always #5 clk = ~clk;

    mealy_run_zero_detector #(.MIN_ONES(1), .MAX_ONES(0), .RUN_W(3), .CNT_W(2)) u_leg (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt), .y(y_l), .y_q(yq_l),
        .state(st_l), .run_len(run_l), .det_cnt(cnt_l), .det_ovf(ovf_l));
    mealy_run_zero_detector #(.MIN_ONES(2), .MAX_ONES(3), .RUN_W(4), .CNT_W(8)) u_win (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt), .y(y_w), .y_q(yq_w),
        .state(st_w), .run_len(run_w), .det_cnt(cnt_w), .det_ovf(ovf_w));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int clip(int r, int sat);
        return r > sat ? sat : r;
    endfunction

    function automatic bit hit_ok(int r, int mn, int mx);
        return r >= mn && (mx == 0 || r <= mx);
    endfunction

    function automatic int st_of(int r, int mn, int mx);
        return r == 0 ? 0 : r < mn ? 1 : hit_ok(r, mn, mx) ? 2 : 3;
    endfunction

    task automatic check_regs();
        chk("run_leg", run_l, clip(run, 7));
        chk("run_win", run_w, clip(run, 15));
        chk("st_leg", st_l, st_of(clip(run, 7), 1, 0));
        chk("st_win", st_w, st_of(clip(run, 15), 2, 3));
        chk("yq_leg", yq_l, yql);
        chk("yq_win", yq_w, yqw);
        chk("cnt_leg", cnt_l, clip(hl, 3));
        chk("cnt_win", cnt_w, clip(hw, 255));
        chk("ovf_leg", ovf_l, ol);
        chk("ovf_win", ovf_w, ow);
    endtask

    task automatic step(input logic e, input logic xi, input logic c);
        bit el, ew;
        @(negedge clk);
        en = e; x = xi; clr_cnt = c;
        #1;
        el = e && !xi && hit_ok(clip(run, 7), 1, 0);
        ew = e && !xi && hit_ok(clip(run, 15), 2, 3);
        chk("y_leg", y_l, el);
        chk("y_win", y_w, ew);
        @(posedge clk);
        yql = el; yqw = ew;
        if (e) run = xi ? run + 1 : 0;
        if (c) begin hl = el; ol = 0; end
        else if (el) begin ol = ol | (hl >= 3); hl++; end
        if (c) begin hw = ew; ow = 0; end
        else if (ew) begin ow = ow | (hw >= 255); hw++; end
        #1;
        check_regs();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_run"}, {run_l, run_w}, 0);
        chk({tag, "_st"}, {st_l, st_w}, 0);
        chk({tag, "_cnt"}, {cnt_l, cnt_w}, 0);
        chk({tag, "_misc"}, {y_l, y_w, yq_l, yq_w, ovf_l, ovf_w}, 0);
    endtask

    initial begin
        logic [7:0] t1;
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        // legacy pattern: hits on the 3rd and 7th bits
        t1 = 8'b00111010;
        for (int i = 0; i < 8; i++) step(1'b1, t1[i], 1'b0);
        chk("t1_cnt", cnt_l, 2);
        // window 2..3: runs of 1,2,3,4 each ended by a 0
        step(1'b1, 1'b0, 1'b1);
        for (int n = 1; n <= 4; n++) begin
            for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0);
            if (n == 4) chk("t2_over", st_w, 3);
            step(1'b1, 1'b0, 1'b0);
        end
        chk("t2_cnt", cnt_w, 2);
        // enable gating holds the run through zeros
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
        chk("t3_hold", run_w, 2);
        step(1'b1, 1'b0, 1'b0);
        chk("t3_yq", yq_w, 1);
        // run-length saturation
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0);
        chk("t4_sat", run_l, 7);
        step(1'b1, 1'b0, 1'b0);
        chk("t4_yq", yq_l, 1);
        // counter saturation, then clear coinciding with a hit
        step(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
        chk("t5_cnt", cnt_l, 3);
        chk("t5_ovf", ovf_l, 1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("t5_clr_cnt", cnt_l, 1);
        chk("t5_clr_ovf", ovf_l, 0);
        // asynchronous reset between edges
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0);
        chk("t6_pre", run_w, 3);
        #2;
        x = 1'b0;
        rst = 1'b0;
        #1;
        check_zero("t6_async");
        run = 0; hl = 0; hw = 0; ol = 0; ow = 0; yql = 0; yqw = 0;
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        // randomized traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
